reg_write_arbiter: RTL

Shares the write port of the 16-bit register bank between several requesters (ALU writeback, load unit, debug port). Each cycle it accepts at most one write request with a round-robin pick, then drives the bank's per-register load enables and shared data bus from a one-cycle output stage. Each register's `en_i`/`d_in` pins are fed directly from this block's outputs.

---
 rtl/reg_wr_pkg.sv | 32 +++
 rtl/reg_write_arbiter_if.sv | 37 +++
 rtl/rr_arbiter.sv | 68 ++++++
 rtl/reg_write_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
// -----------------------------------------------------------------------------
// reg_wr_pkg
// Shared definitions for the register-bank write arbiter:
//   - default bank geometry (DEF_DW, DEF_AW, DEF_NREG)
//   - requester index constants (REQ_ALU, REQ_LOAD, REQ_DBG)
//   - onehot_dec(): address to load-enable decode with range check
// -----------------------------------------------------------------------------
package reg_wr_pkg;

   localparam int DEF_DW   = 16;
   localparam int DEF_AW   = 3;
   localparam int DEF_NREG = 8;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_DBG  = 2;

   // Widest bank the decoder supports (address width up to 8 bits).
   localparam int MAX_NREG = 256;

   // One-hot decode of a register index. An index at or beyond nreg yields
   // all zeros, which turns an out-of-range write into a dropped write.
   // Callers size-cast the result down to their own bank width.
   function automatic logic [MAX_NREG-1:0] onehot_dec(input logic [7:0] addr,
                                                      input int         nreg);
      logic [MAX_NREG-1:0] vec;
      vec = '0;
      if (int'(addr) < nreg) vec[addr] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_if
// Write-request handshake bundle between the requesters and the arbiter.
//   req_valid_i  NREQ     per-requester write request
//   req_ready_o  NREQ     per-requester accept strobe (at most one bit set)
//   req_addr_i   NREQ*AW  packed register index, requester k at [k*AW +: AW]
//   req_data_i   NREQ*DW  packed write data,     requester k at [k*DW +: DW]
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface reg_write_arbiter_if
   import reg_wr_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int DW   = DEF_DW,
   parameter int AW   = DEF_AW
);

   logic [NREQ-1:0]    req_valid_i;
   logic [NREQ-1:0]    req_ready_o;
   logic [NREQ*AW-1:0] req_addr_i;
   logic [NREQ*DW-1:0] req_data_i;

   modport master (
      output req_valid_i,
      output req_addr_i,
      output req_data_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_addr_i,
      input  req_data_i,
      output req_ready_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick over a request vector with a registered priority pointer.
// The grant is combinational from valid and the pointer; after a grant to k
// the pointer moves to (k+1) mod NREQ, otherwise it holds.
// Optional feature macro: RWA_DEBUG_PRIO_EN -- when defined, requester
// NREQ-1 wins whenever it is valid and its grant leaves the pointer alone;
// the other requesters share round-robin among themselves.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; also blocks all grants
//   valid  in   NREQ request vector
//   grant  out  NREQ one-hot grant (all zeros when nothing wins)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] cand;
   logic            found;
   int              idx;

   // NOTE: every variable assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      cand    = valid;
`ifdef RWA_DEBUG_PRIO_EN
      // Debug overrides the rotation and leaves the pointer where it was.
      cand[NREQ-1] = 1'b0;
      if (valid[NREQ-1]) begin
         grant[NREQ-1] = 1'b1;
         found         = 1'b1;
      end
`endif
      // Search upward from ptr, wrapping, first candidate wins.
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!found && cand[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = PW'((idx + 1) % NREQ);
         end
      end
      // Requests pending while reset is held must not be accepted.
      if (reset) grant = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr <= '0;
      else       ptr <= ptr_nxt;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single write port of the register bank among NREQ requesters
// (0 = ALU, 1 = load unit, 2 = debug). At most one request is accepted per
// cycle; the accepted write is registered into a one-cycle output stage that
// drives the bank's per-register load enables and shared data bus.
// Optional feature macro: RWA_DEBUG_PRIO_EN (debug requester priority,
// implemented inside rr_arbiter).
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous, active-high
//   req             --   reg_write_arbiter_if.slave handshake bundle
//   reg_en_o        out  NREG one-hot load enable (0 = no write / dropped)
//   reg_d_o         out  DW shared write data, holds between writes
//   last_grant_o    out  NREQ one-hot of the most recently accepted requester
//   conflict_cnt_o  out  16-bit saturating count of contended cycles
// -----------------------------------------------------------------------------
module reg_write_arbiter
   import reg_wr_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int NREG = DEF_NREG,
   parameter int DW   = DEF_DW,
   parameter int AW   = DEF_AW
) (
   input  logic                clk,
   input  logic                reset,
   reg_write_arbiter_if.slave  req,
   output logic [NREG-1:0]     reg_en_o,
   output logic [DW-1:0]       reg_d_o,
   output logic [NREQ-1:0]     last_grant_o,
   output logic [15:0]         conflict_cnt_o
);

   logic [NREQ-1:0] grant;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic [NREG-1:0] en_nxt;
   logic            xfer;
   logic            contended;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .reset (reset),
      .valid (req.req_valid_i),
      .grant (grant)
   );

   // Ready is the grant itself, so it is never set for an idle requester.
   assign req.req_ready_o = grant;
   assign xfer            = |grant;
   assign contended       = $countones(req.req_valid_i) > 1;

   // AND-OR mux: the grant is one-hot, so at most one term contributes.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            sel_addr = sel_addr | req.req_addr_i[k*AW +: AW];
            sel_data = sel_data | req.req_data_i[k*DW +: DW];
         end
      end
   end

   assign en_nxt = NREG'(onehot_dec(8'(sel_addr), NREG));

   // NOTE: the data register is reset along with the control state because
   // the bank sees reg_d_o directly and must read zero out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_en_o       <= '0;
         reg_d_o        <= '0;
         last_grant_o   <= '0;
         conflict_cnt_o <= '0;
      end else begin
         reg_en_o <= xfer ? en_nxt : '0;
         if (xfer) begin
            reg_d_o      <= sel_data;
            last_grant_o <= grant;
         end
         if (contended && (conflict_cnt_o != 16'hFFFF))
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
   end

endmodule
